// File: rtl/scarv_dmem_responder.sv
// Single-outstanding data-memory responder: grants in IDLE, waits LATENCY cycles,
// then presents a registered response until the requestor acknowledges it.
module scarv_dmem_responder #(
    parameter int MEM_WORDS = 1024,
    parameter int LATENCY   = 2
) (
    input  logic        g_clk,
    input  logic        g_rst,
    input  logic        mem_req,
    output logic        mem_gnt,
    input  logic        mem_wen,
    input  logic [3:0]  mem_strb,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        mem_recv,
    input  logic        mem_ack,
    output logic        mem_error,
    output logic [31:0] mem_rdata,
    output logic [1:0]  dbg_state_o
);
    localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    // Handshakes: a request moves on a cycle where mem_req && mem_gnt; a response
    // moves on a cycle where mem_recv && mem_ack. gnt and recv are never both high.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [3:0]  strb_q, strb_d;
    logic        wen_q, wen_d;
    logic        error_q, error_d;

    logic [31:0]      mem_q [MEM_WORDS];
    logic [IDX_W-1:0] idx;
    logic             addr_err;
    logic             finish;
    logic             wr_en;
    logic [31:0]      rd_word;
    logic [31:0]      wr_word;

    assign idx      = addr_q[IDX_W+1:2];
    assign addr_err = (addr_q[1:0] != 2'b00) || ({2'b00, addr_q[31:2]} >= 32'(MEM_WORDS));
    assign finish   = (state_q == S_WAIT) && (cnt_q == 4'd0);
    assign wr_en    = finish && wen_q && !addr_err;
    assign rd_word  = mem_q[idx];

    always_comb begin
        wr_word = rd_word;
        for (int b = 0; b < 4; b++) begin
            if (strb_q[b]) begin
                wr_word[8*b +: 8] = wdata_q[8*b +: 8];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        strb_d  = strb_q;
        wen_d   = wen_q;
        rdata_d = rdata_q;
        error_d = error_q;
        case (state_q)
            S_IDLE: begin
                if (mem_req) begin
                    addr_d  = mem_addr;
                    wdata_d = mem_wdata;
                    strb_d  = mem_strb;
                    wen_d   = mem_wen;
                    cnt_d   = 4'(LATENCY - 1);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                    error_d = addr_err;
                    rdata_d = (!addr_err && !wen_q) ? rd_word : 32'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (mem_ack) begin
                    state_d = S_IDLE;
                    error_d = 1'b0;
                    rdata_d = 32'd0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge g_clk or posedge g_rst) begin
        if (g_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            strb_q  <= 4'd0;
            wen_q   <= 1'b0;
            rdata_q <= 32'd0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            strb_q  <= strb_d;
            wen_q   <= wen_d;
            rdata_q <= rdata_d;
            error_q <= error_d;
        end
    end

    // The array survives reset; a reset landing on the commit edge drops the write.
    always_ff @(posedge g_clk) begin
        if (wr_en && !g_rst) begin
            mem_q[idx] <= wr_word;
        end
    end

    assign mem_gnt     = (state_q == S_IDLE);
    assign mem_recv    = (state_q == S_RESP);
    assign mem_error   = error_q;
    assign mem_rdata   = rdata_q;
    assign dbg_state_o = state_q;

endmodule
